// File: rtl/regbank16_16bit.sv
// Sixteen-entry, 16-bit register bank with one-hot write decode, parallel read buses
// and a one-entry-per-cycle clear sweep.
module regbank16_16bit #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WE,
    input  logic [3:0]  WADDR,
    input  logic [15:0] WDATA,
    input  logic        CLR,
    output logic        BUSY,
    output logic        WERR,
    output logic [15:0] R0,
    output logic [15:0] R1,
    output logic [15:0] R2,
    output logic [15:0] R3,
    output logic [15:0] R4,
    output logic [15:0] R5,
    output logic [15:0] R6,
    output logic [15:0] R7,
    output logic [15:0] R8,
    output logic [15:0] R9,
    output logic [15:0] R10,
    output logic [15:0] R11,
    output logic [15:0] R12,
    output logic [15:0] R13,
    output logic [15:0] R14,
    output logic [15:0] R15
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SWEEP = 1'b1;

    logic        state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        werr_q, werr_d;
    logic [15:0] mem_q [16];
    logic [15:0] mem_d [16];
    logic [15:0] wen;
    logic        busy;

    assign busy = (state_q == ST_SWEEP);

    // One-hot entry enables; all-zero while sweeping, and entry 0 is never enabled when hardwired.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            if (ZERO_R0 && gi == 0) begin : g_hold
                assign wen[gi] = 1'b0;
            end else begin : g_en
                assign wen[gi] = WE && !busy && (WADDR == 4'(gi));
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        werr_d  = WE && busy;
        for (int i = 0; i < 16; i++) begin
            mem_d[i] = mem_q[i];
            if (wen[i]) begin
                mem_d[i] = WDATA;
            end else if (busy && ptr_q == 4'(i)) begin
                mem_d[i] = '0;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (CLR) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                // Pointer wraps 15 -> 0 on the same edge the sweep finishes.
                ptr_d = ptr_q + 4'd1;
                if (ptr_q == 4'd15) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            werr_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            werr_q  <= werr_d;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign BUSY = busy;
    assign WERR = werr_q;
    assign R0   = ZERO_R0 ? 16'h0000 : mem_q[0];
    assign R1   = mem_q[1];
    assign R2   = mem_q[2];
    assign R3   = mem_q[3];
    assign R4   = mem_q[4];
    assign R5   = mem_q[5];
    assign R6   = mem_q[6];
    assign R7   = mem_q[7];
    assign R8   = mem_q[8];
    assign R9   = mem_q[9];
    assign R10  = mem_q[10];
    assign R11  = mem_q[11];
    assign R12  = mem_q[12];
    assign R13  = mem_q[13];
    assign R14  = mem_q[14];
    assign R15  = mem_q[15];

endmodule

// File: tb/tb_regbank16_16bit.sv
// Scoreboard bench for regbank16_16bit: a behavioural model queues the expected
// outputs for every driven cycle, each scenario task pops and compares them.
module tb_regbank16_16bit;

    logic        CLK = 1'b0;
    logic        RST, WE, CLR;
    logic [3:0]  WADDR;
    logic [15:0] WDATA;
    logic        BUSY, WERR;
    logic [15:0][15:0] dut_r;
    logic        z_busy, z_werr;
    logic [15:0][15:0] zr;

    typedef struct packed {
        logic              busy;
        logic              werr;
        logic [15:0][15:0] r;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] m_mem [16];
    logic        m_busy, m_werr;
    logic [3:0]  m_ptr;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 CLK = ~CLK;

    regbank16_16bit dut (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .CLR(CLR),
        .BUSY(BUSY), .WERR(WERR),
        .R0(dut_r[0]), .R1(dut_r[1]), .R2(dut_r[2]), .R3(dut_r[3]),
        .R4(dut_r[4]), .R5(dut_r[5]), .R6(dut_r[6]), .R7(dut_r[7]),
        .R8(dut_r[8]), .R9(dut_r[9]), .R10(dut_r[10]), .R11(dut_r[11]),
        .R12(dut_r[12]), .R13(dut_r[13]), .R14(dut_r[14]), .R15(dut_r[15])
    );

    regbank16_16bit #(.ZERO_R0(1'b1)) dut_z (
        .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .CLR(CLR),
        .BUSY(z_busy), .WERR(z_werr),
        .R0(zr[0]), .R1(zr[1]), .R2(zr[2]), .R3(zr[3]),
        .R4(zr[4]), .R5(zr[5]), .R6(zr[6]), .R7(zr[7]),
        .R8(zr[8]), .R9(zr[9]), .R10(zr[10]), .R11(zr[11]),
        .R12(zr[12]), .R13(zr[13]), .R14(zr[14]), .R15(zr[15])
    );

    // Drive one cycle, advance the model, queue its expectation, then step past the edge.
    task automatic cyc(input logic rst, input logic we, input logic [3:0] a,
                       input logic [15:0] d, input logic clr);
        exp_t x;
        RST = rst; WE = we; WADDR = a; WDATA = d; CLR = clr;
        if (rst) begin
            for (int k = 0; k < 16; k++) m_mem[k] = 16'h0;
            m_busy = 1'b0; m_ptr = 4'h0; m_werr = 1'b0;
        end else begin
            m_werr = we && m_busy;
            if (m_busy) begin
                m_mem[m_ptr] = 16'h0;
                if (m_ptr == 4'd15) m_busy = 1'b0;
                m_ptr = m_ptr + 4'd1;
            end else begin
                if (we) m_mem[a] = d;
                if (clr) begin
                    m_busy = 1'b1;
                    m_ptr  = 4'h0;
                end
            end
        end
        x.busy = m_busy;
        x.werr = m_werr;
        for (int k = 0; k < 16; k++) x.r[k] = m_mem[k];
        sb.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            cyc(1'b1, 1'b0, 4'h0, 16'h0, 1'b0);
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL reset: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (BUSY !== 1'b0 || WERR !== 1'b0 || dut_r !== '0) begin
            nfail++;
            $display("FAIL reset_const: actual busy=%b werr=%b r=%h required all zero", BUSY, WERR, dut_r);
        end
    endtask

    task automatic test_write_read();
        logic werr_seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            case (n)
                0:       cyc(1'b0, 1'b1, 4'd3, 16'hA5A5, 1'b0);
                1:       cyc(1'b0, 1'b1, 4'd15, 16'h1234, 1'b0);
                default: cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
            endcase
            werr_seen |= WERR;
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL write_read: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (dut_r[3] !== 16'hA5A5 || dut_r[15] !== 16'h1234 || dut_r[0] !== 16'h0 || werr_seen !== 1'b0) begin
            nfail++;
            $display("FAIL write_read_const: actual r3=%h r15=%h r0=%h werr_seen=%b required A5A5 1234 0000 0",
                     dut_r[3], dut_r[15], dut_r[0], werr_seen);
        end
    endtask

    task automatic test_full_decode();
        for (int k = 0; k < 17; k++) begin
            if (k < 16) cyc(1'b0, 1'b1, 4'(k), 16'h1000 + 16'(k), 1'b0);
            else        cyc(1'b0, 1'b1, 4'd7, 16'hFFFF, 1'b0);
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL full_decode[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         k, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (dut_r[7] !== 16'hFFFF || dut_r[6] !== 16'h1006 || dut_r[8] !== 16'h1008) begin
            nfail++;
            $display("FAIL decode_const: actual r6=%h r7=%h r8=%h required 1006 FFFF 1008",
                     dut_r[6], dut_r[7], dut_r[8]);
        end
    endtask

    task automatic test_sweep();
        int busy_cnt = 0;
        for (int n = 0; n < 18; n++) begin
            cyc(1'b0, 1'b0, 4'd0, 16'h0, n == 0);
            if (BUSY === 1'b1) busy_cnt++;
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL sweep[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         n, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (busy_cnt != 16 || dut_r !== '0) begin
            nfail++;
            $display("FAIL sweep_len: actual busy_cycles=%0d r=%h required 16 cycles, bank zero", busy_cnt, dut_r);
        end
    endtask

    task automatic test_write_during_sweep();
        int busy_cnt = 0;
        int werr_cnt = 0;
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 4'(k), 16'h2000 + 16'(k), 1'b0);
        repeat (16) void'(sb.pop_front());
        for (int n = 0; n < 19; n++) begin
            // n=0 issues CLR, n=5 writes in the 5th BUSY cycle, n=6 re-issues CLR
            cyc(1'b0, n == 5, 4'd9, 16'hBEEF, n == 0 || n == 6);
            if (BUSY === 1'b1) busy_cnt++;
            if (WERR === 1'b1) werr_cnt++;
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL sweep_write[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         n, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (busy_cnt != 16 || werr_cnt != 1 || dut_r[9] !== 16'h0) begin
            nfail++;
            $display("FAIL sweep_write_const: actual busy_cycles=%0d werr_cycles=%0d r9=%h required 16 1 0000",
                     busy_cnt, werr_cnt, dut_r[9]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int k = 0; k < 16; k++) cyc(1'b0, 1'b1, 4'(k), 16'h3000 + 16'(k), 1'b0);
        repeat (16) void'(sb.pop_front());
        for (int n = 0; n < 11; n++) begin
            if (n == 8)       cyc(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
            else if (n == 10) cyc(1'b0, 1'b1, 4'd2, 16'h0042, 1'b0);
            else              cyc(1'b0, 1'b0, 4'd0, 16'h0, n == 0);
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL reset_mid_sweep[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         n, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
        end
        ncmp++;
        if (BUSY !== 1'b0 || dut_r[2] !== 16'h0042 || dut_r[15] !== 16'h0) begin
            nfail++;
            $display("FAIL reset_mid_const: actual busy=%b r2=%h r15=%h required 0 0042 0000", BUSY, dut_r[2], dut_r[15]);
        end
    endtask

    task automatic test_back_to_back();
        int werr_cnt = 0;
        for (int n = 0; n < 18; n++) begin
            // CLR with a write on the same edge, then two consecutive dropped writes
            if (n == 0)           cyc(1'b0, 1'b1, 4'd4, 16'h4444, 1'b1);
            else if (n <= 2)      cyc(1'b0, 1'b1, 4'd5, 16'h5555, 1'b0);
            else                  cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
            if (WERR === 1'b1) werr_cnt++;
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL back_to_back[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         n, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
            if (n == 0) begin
                ncmp++;
                if (dut_r[4] !== 16'h4444 || BUSY !== 1'b1) begin
                    nfail++;
                    $display("FAIL clr_with_write: actual r4=%h busy=%b required 4444 1", dut_r[4], BUSY);
                end
            end
        end
        ncmp++;
        if (werr_cnt != 2 || dut_r[4] !== 16'h0 || dut_r[5] !== 16'h0) begin
            nfail++;
            $display("FAIL back_to_back_const: actual werr_cycles=%0d r4=%h r5=%h required 2 0000 0000",
                     werr_cnt, dut_r[4], dut_r[5]);
        end
    endtask

    task automatic test_zero_r0();
        for (int n = 0; n < 4; n++) begin
            case (n)
                0:       cyc(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
                1:       cyc(1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0);
                2:       cyc(1'b0, 1'b1, 4'd1, 16'h0001, 1'b0);
                default: cyc(1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
            endcase
            e = sb.pop_front();
            ncmp++;
            if ({BUSY, WERR, dut_r} !== e) begin
                nfail++;
                $display("FAIL zero_r0_ref[%0d]: actual busy=%b werr=%b r=%h required busy=%b werr=%b r=%h",
                         n, BUSY, WERR, dut_r, e.busy, e.werr, e.r);
            end
            ncmp++;
            if (zr[0] !== 16'h0 || z_werr !== 1'b0 || z_busy !== 1'b0) begin
                nfail++;
                $display("FAIL zero_r0[%0d]: actual r0=%h werr=%b busy=%b required 0000 0 0", n, zr[0], z_werr, z_busy);
            end
        end
        ncmp++;
        if (zr[1] !== 16'h0001 || dut_r[0] !== 16'hFFFF) begin
            nfail++;
            $display("FAIL zero_r0_r1: actual z_r1=%h ref_r0=%h required 0001 FFFF", zr[1], dut_r[0]);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_full_decode();
        test_sweep();
        test_write_during_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        test_zero_r0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/regbank16_16bit.md
# regbank16_16bit

Sixteen-entry, 16-bit register bank forming the write side of the datapath's 16-way selection. A 4-bit write address is decoded into one of sixteen register enables. All sixteen register values are driven in parallel, one bus each, so they connect directly to the inputs of the 16:1 16-bit read multiplexer. A sequenced clear engine zeroes the bank one entry per cycle on request. The block sits between the writeback stage and the operand-select muxes of the single-cycle core.

## Interface
- ZERO_R0, default 0: when 1, entry 0 ignores writes and always reads 16'h0000.
- CLK  input  1  rising-edge clock; all state changes on this edge.
- RST  input  1  synchronous, active-high reset; sampled on CLK rising edge.
- WE  input  1  write enable.
- WADDR  input  4  write address; decoded one-hot to entry enables.
- WDATA  input  16  write data.
- CLR  input  1  request for a sequenced bank clear.
- BUSY  output  1  high while the clear sweep is in progress.
- WERR  output  1  one-cycle pulse: a write was dropped because BUSY was high.
- R0 … R15  output  16 each  current contents of entries 0–15; R0–R15 map to mux inputs A–P in order.

## Operation
- Reset: on any edge with RST=1, all entries, R0–R15, BUSY, WERR, and the sweep pointer go to 0, and the FSM goes to IDLE. RST overrides every other input, including an active sweep.
- FSM states:
  - IDLE: writes allowed.
  - SWEEP: clearing in progress; the 4-bit pointer PTR selects the entry.
- IDLE → SWEEP: on an edge where CLR=1. PTR←0 and BUSY←1.
- SWEEP: each edge clears entry[PTR] to 0 and increments PTR.
  - On the edge that clears entry 15, go to IDLE and set BUSY←0. PTR wraps to 0.
  - CLR is ignored while in SWEEP; there is no restart and no queueing.
- Write in IDLE: on an edge with WE=1 and BUSY=0, entry[WADDR]←WDATA. No other entry changes.
- Write during SWEEP: on an edge with WE=1 and BUSY=1, the write is dropped and WERR=1 for exactly the next cycle. Otherwise WERR=0.
- CLR=1 and WE=1 on the same IDLE edge: the write commits, the sweep starts, and the sweep later zeroes that entry.
- ZERO_R0=1: R0 is constantly 0. A write to address 0 is silently discarded and does not raise WERR.
- Only one entry enable is active per edge. The decoder output is all-zero when WE=0 or BUSY=1.

## Timing
- Write latency: WDATA is visible on R[WADDR] in the cycle after the committing edge. There is no read-through bypass.
- Clear sweep: BUSY is high for exactly 16 cycles, beginning the cycle after CLR is sampled.
  - Entry k reads 0 from cycle k+1 after BUSY rises.
  - The whole bank reads 0 in the first cycle after BUSY falls.
- WERR is registered: it asserts 1 cycle after the dropped write's edge and lasts 1 cycle per dropped write. Back-to-back dropped writes hold WERR high continuously.
- Outputs R0–R15 are register outputs with no combinational path from the inputs.
- Minimum CLR re-issue: one IDLE edge after BUSY falls.

## Test plan
- Reset then write/read: after RST, write 16'hA5A5 to address 3 and 16'h1234 to address 15 on consecutive edges → R3=A5A5, R15=1234, all other outputs 0, WERR never asserted.
- Full decode: write 16'h1000+k to address k for k=0..15 → each Rk=1000+k. Overwrite address 7 with FFFF → only R7 changes.
- Clear sweep: with all entries nonzero, pulse CLR for 1 cycle → BUSY high exactly 16 cycles, R0..R15 zero in ascending order one per cycle, BUSY low afterwards.
- Write during sweep: issue WE at address 9, WDATA=BEEF, in the 5th BUSY cycle → write not applied, WERR high exactly 1 cycle, R9=0 at sweep end. Repeat CLR during BUSY → no sweep extension.
- Reset mid-sweep: assert RST in the 8th BUSY cycle → next cycle BUSY=0, all Rk=0. A write of 0x0042 to address 2 one cycle later commits normally.
- ZERO_R0=1 build: write 16'hFFFF to address 0 and 16'h0001 to address 1 → R0=0, R1=1, WERR stays 0.
